// File: rtl/kernel_writer.sv
// kernel_writer: DEPTH-entry coefficient store loaded through a valid/ready stream.
// Optional feature macro KERNEL_CHECKSUM_EN adds an 8-bit running sum of loaded data.
module kernel_writer #(
    parameter int DEPTH = 9,
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [3:0]       address,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [3:0]       wr_count
`ifdef KERNEL_CHECKSUM_EN
    ,
    output logic [7:0]       checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             xfer;
    logic             last;
    logic             go;

    // Default kernel repeats 1,2,1,0 across the store
    function automatic logic [WIDTH-1:0] dflt(input int i);
        case (i % 4)
            1:       return WIDTH'(2);
            3:       return WIDTH'(0);
            default: return WIDTH'(1);
        endcase
    endfunction

    assign go   = (state_q == IDLE) && start;
    assign xfer = din_ready && din_valid;
    assign last = (wr_count == 4'(DEPTH - 1));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        din_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (din_valid && last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= dflt(i);
        end else if (go) begin
            wr_count <= '0;
        end else if (xfer) begin
            mem[wr_count] <= din;
            wr_count      <= wr_count + 4'd1;
        end
    end

    assign data = (int'(address) < DEPTH) ? mem[address] : '0;

`ifdef KERNEL_CHECKSUM_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            checksum <= '0;
        end else if (go) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + 8'(din);
        end
    end
`endif

endmodule

// File: tb/tb_kernel_writer.sv
// Bench for kernel_writer: reset/readback table, directed load sequences,
// then randomized traffic against a behavioural store model.
module tb_kernel_writer;

    localparam int DEPTH = 9;
    localparam int WIDTH = 4;

    logic             CLK = 1'b0;
    logic             RST_n = 1'b0;
    logic             start = 1'b0;
    logic             din_valid = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [3:0]       address = '0;
    logic             din_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data;
    logic [3:0]       wr_count;
`ifdef KERNEL_CHECKSUM_EN
    logic [7:0]       checksum;
`endif

    int n_chk = 0;
    int n_fail = 0;

    int dflt[DEPTH] = '{1, 2, 1, 0, 1, 2, 1, 0, 1};

    typedef struct {
        int addr;
        int exp;
    } rd_vec_t;

    rd_vec_t rv[16];

    // behavioural model: 0 idle, 1 loading, 2 finished
    int m_mem[DEPTH];
    int m_cnt;
    int m_phase;
    int m_sum;

    always #5 CLK = ~CLK;

    kernel_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .start    (start),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .address  (address),
        .data     (data),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count)
`ifdef KERNEL_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input string name, input int a, input int exp);
        address = 4'(a);
        @(negedge CLK);
        chk(name, int'(data), exp);
    endtask

    task automatic chk_csum(input string name, input int exp);
`ifdef KERNEL_CHECKSUM_EN
        chk(name, int'(checksum), exp);
`endif
    endtask

    initial begin
        int cycles;
        int st, v, d, a, e;

        for (int i = 0; i < 16; i++) begin
            rv[i].addr = i;
            rv[i].exp  = (i < DEPTH) ? dflt[i] : 0;
        end

        // reset state and default kernel
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(din_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(wr_count), 0);
        chk_csum("rst_csum", 0);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) rd("rst_rd", rv[i].addr, rv[i].exp);
        @(posedge CLK);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(din_ready), 0);

        // back-to-back load 1..9 with a stall first
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ld_busy", int'(busy), 1);
        chk("ld_ready", int'(din_ready), 1);
        chk("ld_cnt0", int'(wr_count), 0);
        chk_csum("ld_csum0", 0);
        tick();
        tick();
        chk("stall_cnt", int'(wr_count), 0);
        chk("stall_busy", int'(busy), 1);
        for (int i = 1; i <= 9; i++) begin
            din       = 4'(i);
            din_valid = 1'b1;
            if (i < 9) begin
                tick();
                chk("ld_nodone", int'(done), 0);
            end else begin
                tick();
            end
        end
        din_valid = 1'b0;
        chk("ld_done", int'(done), 1);
        chk("ld_done_busy", int'(busy), 0);
        chk("ld_done_ready", int'(din_ready), 0);
        chk("ld_cnt9", int'(wr_count), 9);
        chk_csum("ld_csum45", 45);
        tick();
        chk("ld_done_once", int'(done), 0);
        chk("ld_cnt_hold", int'(wr_count), 9);
        chk_csum("ld_csum_hold", 45);
        for (int i = 0; i < DEPTH; i++) rd("ld_rd", i, i + 1);
        @(posedge CLK);
        #1;

        // alternating valid, din = 15
        start = 1'b1;
        tick();
        start = 1'b0;
        address = 4'd0;
        din = 4'd15;
        #1;
        chk("rdw_old", int'(data), 1);
        cycles = 0;
        while (!done && cycles < 40) begin
            din_valid = (cycles % 2 == 0);
            tick();
            cycles++;
            if (cycles == 1) chk("rdw_new", int'(data), 15);
        end
        chk("alt_cycles", cycles, 17);
        chk("alt_done", int'(done), 1);
        chk("alt_cnt", int'(wr_count), 9);
        chk_csum("alt_csum135", 135);
        din_valid = 1'b1;
        din = 4'd0;
        tick();
        chk("alt_done_once", int'(done), 0);
        tick();
        chk("alt_idle_busy", int'(busy), 0);
        chk("alt_idle_cnt", int'(wr_count), 9);
        chk_csum("alt_csum_hold", 135);
        din_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) rd("alt_rd", i, 15);
        @(posedge CLK);
        #1;

        // partial load, restart ignored, reset abort
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_csum("new_csum0", 0);
        din = 4'd7;
        din_valid = 1'b1;
        repeat (4) tick();
        din_valid = 1'b0;
        chk("ab_cnt4", int'(wr_count), 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_restart_cnt", int'(wr_count), 4);
        chk("ab_restart_busy", int'(busy), 1);
        RST_n = 1'b0;
        #1;
        chk("ab_busy", int'(busy), 0);
        chk("ab_ready", int'(din_ready), 0);
        chk("ab_cnt", int'(wr_count), 0);
        chk("ab_done", int'(done), 0);
        chk_csum("ab_csum", 0);
        for (int i = 0; i < 4; i++) rd("ab_rd", i, dflt[i]);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_cnt", int'(wr_count), 0);

        // randomized traffic against the model
        for (int i = 0; i < DEPTH; i++) m_mem[i] = dflt[i];
        m_cnt = 0;
        m_phase = 0;
        m_sum = 0;
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 7) == 0) ? 1 : 0;
            v  = int'($urandom_range(0, 1));
            d  = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, 15));
            start = st[0];
            din_valid = v[0];
            din = 4'(d);
            address = 4'(a);
            #1;
            e = (a < DEPTH) ? m_mem[a] : 0;
            chk("rnd_data", int'(data), e);
            chk("rnd_busy", int'(busy), (m_phase == 1) ? 1 : 0);
            chk("rnd_ready", int'(din_ready), (m_phase == 1) ? 1 : 0);
            chk("rnd_done", int'(done), (m_phase == 2) ? 1 : 0);
            chk("rnd_cnt", int'(wr_count), m_cnt);
            chk_csum("rnd_csum", m_sum);
            @(posedge CLK);
            if (m_phase == 0) begin
                if (st != 0) begin
                    m_phase = 1;
                    m_cnt = 0;
                    m_sum = 0;
                end
            end else if (m_phase == 1) begin
                if (v != 0) begin
                    m_mem[m_cnt] = d;
                    m_cnt++;
                    m_sum = (m_sum + d) % 256;
                    if (m_cnt == DEPTH) m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
            #1;
        end
        start = 1'b0;
        din_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_writer.md
KERNEL_WRITER -- requirements
Module: kernel_writer

Interface
REQ-001 Parameter DEPTH, default 9, number of kernel coefficients (3x3 window).
REQ-002 Parameter WIDTH, default 4, bits per coefficient.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  pulse; begins a kernel load sequence.
REQ-006 din  input  WIDTH  coefficient to write.
REQ-007 din_valid  input  1  din holds a valid coefficient.
REQ-008 din_ready  output  1  block accepts din this cycle.
REQ-009 address  input  4  read index into kernel store.
REQ-010 data  output  WIDTH  coefficient at address, combinational.
REQ-011 busy  output  1  load sequence in progress.
REQ-012 done  output  1  one-cycle pulse, all DEPTH coefficients written.
REQ-013 wr_count  output  4  number of coefficients accepted in the current load.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, DONE; encoding is free.
REQ-015 IDLE: din_ready=0, busy=0; start=1 -> LOAD, wr_count cleared to 0.
REQ-016 LOAD: din_ready=1, busy=1; transfer occurs when din_valid and din_ready are both 1 at a rising edge.
REQ-017 Transfer: mem[wr_count] <= din, wr_count <= wr_count+1.
REQ-018 Transfer with wr_count==DEPTH-1 -> DONE; no further transfer is accepted that cycle onward (din_ready=0 in DONE).
REQ-019 DONE: done=1 for exactly one cycle, busy=0, then unconditional -> IDLE; wr_count holds DEPTH until next start.
REQ-020 start asserted in LOAD or DONE SHALL be ignored; no restart, no clearing.
REQ-021 din_valid=0 in LOAD: no write, state and wr_count hold; no timeout.
REQ-022 din_valid in IDLE or DONE SHALL be ignored (no write).
REQ-023 data = mem[address] for address < DEPTH; data = 0 for address >= DEPTH.
REQ-024 A write to entry k SHALL be visible on data the cycle after the transfer edge; read during write returns old value.
REQ-025 Entries not yet rewritten in a load retain previous contents.
REQ-026 wr_count SHALL never exceed DEPTH; no wrap-around.

Reset
REQ-027 RST_n=0 SHALL immediately force state IDLE, wr_count=0, done=0, busy=0, din_ready=0.
REQ-028 RST_n=0 SHALL load mem with default kernel 1,2,1,0,1,2,1,0,1 (entries 0..8).
REQ-029 Reset asserted mid-LOAD SHALL abort the load; partial writes are discarded (defaults restored).
REQ-030 After RST_n deasserts, block SHALL idle until start.

Configuration
REQ-031 Macro KERNEL_CHECKSUM_EN SHALL gate a checksum feature.
REQ-032 Defined: output checksum[7:0]; cleared to 0 on start accepted in IDLE and on reset; adds zero-extended din on each transfer; final value stable from the DONE cycle until next start.
REQ-033 Not defined: checksum port and logic absent; all other behaviour identical.

Verification
REQ-034 Reset, then read address 0..8 -> data 1,2,1,0,1,2,1,0,1; address 9..15 -> 0; din_ready=0, busy=0.
REQ-035 start, then 9 back-to-back transfers din=1..9 -> done pulses one cycle after 9th transfer edge; reads 0..8 return 1..9; wr_count=9.
REQ-036 start, din_valid toggled 1/0 each cycle with din=15 -> 9 transfers in 17 cycles, done once, all entries 15; din presented in DONE/IDLE not written.
REQ-037 start, 4 transfers din=7, RST_n pulsed low -> state IDLE, entries 0..3 read 1,2,1,0; second start mid-LOAD has no effect on wr_count.
REQ-038 With KERNEL_CHECKSUM_EN: load 1..9 -> checksum=45; load all 15 -> checksum=135; new start clears checksum to 0.
